// File: rtl/carregador_de_instrucoes.sv
// carregador_de_instrucoes: loads big-endian 32-bit words from a byte stream into instruction memory while holding the CPU
// Optional CARREGADOR_CHECKSUM_EN adds a trailing XOR checksum byte checked in state CHECA.
module carregador_de_instrucoes #(
  parameter int ADDR_W    = 26,
  parameter int MEM_SIZE  = 150,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] num_palavras,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              concluido,
  output logic              erro
);
  typedef enum logic [2:0] {OCIOSO, RECEBE, ESCREVE, CHECA, FIM} estado_t;
  localparam logic [ADDR_W-1:0] LIMITE = ADDR_W'(MEM_SIZE - BASE_ADDR);
`ifdef CARREGADOR_CHECKSUM_EN
  localparam estado_t APOS_ULTIMA = CHECA;
  logic [7:0] soma;
`else
  localparam estado_t APOS_ULTIMA = FIM;
`endif
  estado_t estado, prox;
  logic [ADDR_W-1:0] n, idx;
  logic [1:0] cnt;
  logic [23:0] parcial;
  logic aceita, inicia;
  assign byte_ready = estado == RECEBE || estado == CHECA;
  assign aceita     = byte_valid && byte_ready;
  assign inicia     = estado == OCIOSO && iniciar;
  assign wr_en      = estado == ESCREVE;
  assign cpu_hold   = estado != OCIOSO;
  assign concluido  = estado == FIM;
  always_ff @(posedge clock or posedge reset)
    if (reset) estado <= OCIOSO;
    else estado <= prox;
  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:  prox = !iniciar ? OCIOSO : (num_palavras == '0 || num_palavras > LIMITE) ? FIM : RECEBE;
      RECEBE:  prox = (aceita && cnt == 2'd3) ? ESCREVE : RECEBE;
      ESCREVE: prox = (idx + 1'b1 == n) ? APOS_ULTIMA : RECEBE;
      CHECA:   prox = aceita ? FIM : CHECA;
      FIM:     prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end
  // Output word/address are latched with the 4th byte so they stay stable outside the write cycle.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      n       <= '0;
      idx     <= '0;
      cnt     <= '0;
      parcial <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      erro    <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      soma    <= '0;
`endif
    end else begin
      if (inicia) begin
        n    <= num_palavras;
        idx  <= '0;
        cnt  <= '0;
        erro <= num_palavras > LIMITE;
`ifdef CARREGADOR_CHECKSUM_EN
        soma <= '0;
`endif
      end
      if (estado == RECEBE && aceita) begin
        parcial <= {parcial[15:0], byte_in};
        cnt     <= cnt + 2'd1;
`ifdef CARREGADOR_CHECKSUM_EN
        soma    <= soma ^ byte_in;
`endif
        if (cnt == 2'd3) begin
          wr_data <= {parcial, byte_in};
          wr_addr <= ADDR_W'(BASE_ADDR) + idx;
        end
      end
      if (estado == ESCREVE) idx <= idx + 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
      if (estado == CHECA && aceita) erro <= byte_in != soma;
`endif
    end
endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// tb_carregador_de_instrucoes: directed self-checking bench for the instruction loader
module tb_carregador_de_instrucoes;
  localparam int AW = 26;
  logic          clock = 1'b0, reset = 1'b1, iniciar = 1'b0, byte_valid = 1'b0;
  logic [AW-1:0] num_palavras = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_ready, wr_en, cpu_hold, concluido, erro;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [7:0]    csum = '0;
  int total = 0, passed = 0, wr_count = 0, base_count = 0;

  carregador_de_instrucoes #(.ADDR_W(AW), .MEM_SIZE(150), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .num_palavras(num_palavras),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .concluido(concluido), .erro(erro)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (wr_en) wr_count <= wr_count + 1;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start(input int n);
    num_palavras = AW'(n);
    iniciar = 1'b1;
    csum = '0;
    tick;
    iniciar = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in = b;
    csum ^= b;
    tick;
    byte_valid = 1'b0;
    byte_in = 8'h5A;
  endtask

  task automatic word(input string tag, input logic [31:0] w, input logic [31:0] addr);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
    chk({tag, " wr_en"}, 32'(wr_en), 1);
    chk({tag, " wr_addr"}, 32'(wr_addr), addr);
    chk({tag, " wr_data"}, wr_data, w);
    chk({tag, " ready_in_write"}, 32'(byte_ready), 0);
    tick;
  endtask

  task automatic finish(input string tag, input logic e);
`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0] c;
    c = csum;
    chk({tag, " checa_ready"}, 32'(byte_ready), 1);
    send(c);
`endif
    chk({tag, " concluido"}, 32'(concluido), 1);
    chk({tag, " erro"}, 32'(erro), 32'(e));
    chk({tag, " hold_in_fim"}, 32'(cpu_hold), 1);
    tick;
    chk({tag, " concluido_off"}, 32'(concluido), 0);
    chk({tag, " hold_off"}, 32'(cpu_hold), 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst cpu_hold", 32'(cpu_hold), 0);
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst concluido", 32'(concluido), 0);
    chk("rst erro", 32'(erro), 0);
    chk("rst byte_ready", 32'(byte_ready), 0);
    chk("rst wr_data", wr_data, 0);
    reset = 1'b0;
    tick;

    // two words, continuous stream
    base_count = wr_count;
    start(2);
    chk("t1 hold", 32'(cpu_hold), 1);
    chk("t1 ready", 32'(byte_ready), 1);
    word("t1 w0", 32'h7C000001, 0);
    chk("t1 ready_after_w0", 32'(byte_ready), 1);
    word("t1 w1", 32'h08630001, 1);
    finish("t1", 1'b0);
    chk("t1 writes", 32'(wr_count - base_count), 2);
    chk("t1 hold_data", wr_data, 32'h08630001);

    // byte_valid toggling every cycle
    base_count = wr_count;
    start(1);
    for (int i = 0; i < 4; i++) begin
      send(8'h11 * 8'(i + 1));
      if (i < 3) begin
        chk("t2 ready_gap", 32'(byte_ready), 1);
        tick;
      end
    end
    chk("t2 wr_en", 32'(wr_en), 1);
    chk("t2 wr_addr", 32'(wr_addr), 0);
    chk("t2 wr_data", wr_data, 32'h11223344);
    chk("t2 ready_in_write", 32'(byte_ready), 0);
    tick;
    finish("t2", 1'b0);
    chk("t2 writes", 32'(wr_count - base_count), 1);

    // N=0 and oversized N
    base_count = wr_count;
    start(0);
    chk("t3 n0 concluido", 32'(concluido), 1);
    chk("t3 n0 erro", 32'(erro), 0);
    tick;
    start(151);
    chk("t3 big concluido", 32'(concluido), 1);
    chk("t3 big erro", 32'(erro), 1);
    tick;
    chk("t3 big erro_sticky", 32'(erro), 1);
    chk("t3 big hold_off", 32'(cpu_hold), 0);
    chk("t3 writes", 32'(wr_count - base_count), 0);

    // N=MEM_SIZE is accepted; reset mid-word aborts
    start(150);
    chk("t4 max erro_cleared", 32'(erro), 0);
    chk("t4 max ready", 32'(byte_ready), 1);
    send(8'h12);
    send(8'h34);
    reset = 1'b1;
    #1;
    chk("t4 rst hold", 32'(cpu_hold), 0);
    chk("t4 rst ready", 32'(byte_ready), 0);
    chk("t4 rst wr_data", wr_data, 0);
    chk("t4 rst concluido", 32'(concluido), 0);
    tick;
    reset = 1'b0;
    tick;
    start(1);
    word("t4 w0", 32'hAABBCCDD, 0);
    finish("t4", 1'b0);

    // iniciar while receiving is ignored
    start(2);
    send(8'h01);
    iniciar = 1'b1;
    num_palavras = AW'(1);
    send(8'h02);
    iniciar = 1'b0;
    send(8'h03);
    send(8'h04);
    chk("t5 w0 wr_data", wr_data, 32'h01020304);
    tick;
    chk("t5 still_loading", 32'(concluido), 0);
    chk("t5 ready", 32'(byte_ready), 1);
    word("t5 w1", 32'h05060708, 1);
    finish("t5", 1'b0);

`ifdef CARREGADOR_CHECKSUM_EN
    start(1);
    word("t6 ok", 32'h01020304, 0);
    send(8'h04);
    chk("t6 ok concluido", 32'(concluido), 1);
    chk("t6 ok erro", 32'(erro), 0);
    tick;
    start(1);
    word("t6 bad", 32'h01020304, 0);
    send(8'h05);
    chk("t6 bad concluido", 32'(concluido), 1);
    chk("t6 bad erro", 32'(erro), 1);
    tick;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
